// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: data priority with a starvation bound, an
// address-phase lock, and an ID FIFO that routes responses back in order.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_OPEN   | no request stalled; the grant is chosen freshly each cycle
// ST_LOCKED | the grant was presented but not accepted; hold it via lock_id
module sram_like_arbiter #(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,

  output logic        err_unexp
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t       lock_st, lock_nxt;
  logic              lock_id;
  logic [STV_W-1:0]  starve_cnt;
  logic [MAX_OUT-1:0] fifo_mem;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic gnt_id;
  logic gnt_req;
  logic full;
  logic hs;
  logic push, pop;
  logic head;
  logic resp_ok;

  assign full = (count == CNT_FULL);

  always_comb begin
    gnt_id = ID_DATA;
    if (lock_st == ST_LOCKED) begin
      gnt_id = lock_id;
    end else if (inst_req && !data_req) begin
      gnt_id = ID_INST;
    end else if (data_req && !inst_req) begin
      gnt_id = ID_DATA;
    end else if (inst_req && data_req) begin
      gnt_id = (starve_cnt == STV_LIMIT) ? ID_INST : ID_DATA;
    end
  end

  assign gnt_req = (gnt_id == ID_DATA) ? data_req : inst_req;
  // full is registered state only, so m_data_ok never reaches m_req
  assign m_req   = gnt_req & ~full;
  assign hs      = m_req & m_addr_ok;

  assign m_wr    = (gnt_id == ID_DATA) ? data_wr    : inst_wr;
  assign m_size  = (gnt_id == ID_DATA) ? data_size  : inst_size;
  assign m_addr  = (gnt_id == ID_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (gnt_id == ID_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = hs & (gnt_id == ID_INST);
  assign data_addr_ok = hs & (gnt_id == ID_DATA);

  assign push    = hs;
  assign resp_ok = m_data_ok & (count != '0);
  assign pop     = resp_ok;
  assign head    = fifo_mem[rd_ptr];

  assign inst_data_ok = resp_ok & (head == ID_INST);
  assign data_data_ok = resp_ok & (head == ID_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  always_comb begin
    lock_nxt = lock_st;
    case (lock_st)
      ST_OPEN:   if (m_req && !m_addr_ok) lock_nxt = ST_LOCKED;
      ST_LOCKED: if (hs) lock_nxt = ST_OPEN;
      default:   lock_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_st <= ST_OPEN;
      lock_id <= 1'b0;
    end else begin
      lock_st <= lock_nxt;
      if (lock_st == ST_OPEN && m_req && !m_addr_ok) lock_id <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (data_addr_ok && starve_cnt != STV_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= gnt_id;
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                       err_unexp <= 1'b0;
    else if (m_data_ok && count == '0) err_unexp <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, state commits on the following rising edge.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;
  logic        err_unexp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 1; data_size = 2'd2;
    data_addr = 32'h1111_2222; data_wdata = 32'hAAAA_5555;
    m_rdata = '0; m_addr_ok = 1'b1; m_data_ok = 1'b1;

    // reset: payload follows data side, nothing routed with count 0
    repeat (2) cyc();
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 32'h1111_2222);
    chk("rst_m_wdata", m_wdata, 32'hAAAA_5555);
    chk("rst_m_wr", m_wr, 1);
    chk("rst_m_size", m_size, 2);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_err", err_unexp, 0);

    cyc();
    resetn = 1'b1; m_data_ok = 1'b0; m_addr_ok = 1'b0; data_wr = 0;
    #1 chk("post_rst_err", err_unexp, 0);

    // single inst read
    cyc();
    inst_req = 1; inst_addr = 32'h1FC0_0000; m_addr_ok = 1;
    #1;
    chk("rd_m_req", m_req, 1);
    chk("rd_m_addr", m_addr, 32'h1FC0_0000);
    chk("rd_inst_addr_ok", inst_addr_ok, 1);
    chk("rd_data_addr_ok", data_addr_ok, 0);
    cyc();
    inst_req = 0; m_addr_ok = 0;
    #1;
    chk("rd_c1_inst_data_ok", inst_data_ok, 0);
    chk("rd_c1_m_req", m_req, 0);
    cyc();
    m_data_ok = 1; m_rdata = 32'h3C08_0001;
    #1;
    chk("rd_c2_inst_data_ok", inst_data_ok, 1);
    chk("rd_c2_data_data_ok", data_data_ok, 0);
    chk("rd_c2_inst_rdata", inst_rdata, 32'h3C08_0001);

    // simultaneous requests: data first, inst next
    cyc();
    m_data_ok = 0;
    inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_addr = 32'h0000_0200; m_addr_ok = 1;
    #1;
    chk("sim0_m_addr", m_addr, 32'h0000_0200);
    chk("sim0_data_addr_ok", data_addr_ok, 1);
    chk("sim0_inst_addr_ok", inst_addr_ok, 0);
    cyc();
    data_req = 0;
    #1;
    chk("sim1_m_addr", m_addr, 32'h0000_0100);
    chk("sim1_inst_addr_ok", inst_addr_ok, 1);
    chk("sim1_data_addr_ok", data_addr_ok, 0);
    cyc();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA_0001;
    #1;
    chk("simA_data_data_ok", data_data_ok, 1);
    chk("simA_inst_data_ok", inst_data_ok, 0);
    chk("simA_data_rdata", data_rdata, 32'hAAAA_0001);
    cyc();
    m_rdata = 32'hBBBB_0002;
    #1;
    chk("simB_inst_data_ok", inst_data_ok, 1);
    chk("simB_data_data_ok", data_data_ok, 0);
    chk("simB_inst_rdata", inst_rdata, 32'hBBBB_0002);

    // lock: data stalled 3 cycles, inst rises, payload must not switch
    cyc();
    m_data_ok = 0; data_req = 1; data_addr = 32'h0000_0300; m_addr_ok = 0;
    #1;
    chk("lk0_m_req", m_req, 1);
    chk("lk0_m_addr", m_addr, 32'h0000_0300);
    chk("lk0_data_addr_ok", data_addr_ok, 0);
    cyc(); cyc();
    #1 chk("lk2_m_addr", m_addr, 32'h0000_0300);
    cyc();
    inst_req = 1; inst_addr = 32'h0000_0400; m_addr_ok = 1;
    #1;
    chk("lk3_m_addr", m_addr, 32'h0000_0300);
    chk("lk3_data_addr_ok", data_addr_ok, 1);
    chk("lk3_inst_addr_ok", inst_addr_ok, 0);
    // inst granted next and stalled; a new data request must not steal it
    cyc();
    data_req = 0; m_addr_ok = 0;
    #1;
    chk("lk4_m_addr", m_addr, 32'h0000_0400);
    chk("lk4_inst_addr_ok", inst_addr_ok, 0);
    cyc();
    data_req = 1; data_addr = 32'h0000_0500;
    #1;
    chk("lk5_m_addr", m_addr, 32'h0000_0400);
    chk("lk5_m_req", m_req, 1);
    cyc();
    m_addr_ok = 1;
    #1;
    chk("lk6_m_addr", m_addr, 32'h0000_0400);
    chk("lk6_inst_addr_ok", inst_addr_ok, 1);
    chk("lk6_data_addr_ok", data_addr_ok, 0);

    // full: two outstanding (D 0x300, I 0x400)
    cyc();
    inst_req = 0;
    #1;
    chk("f0_m_req", m_req, 0);
    chk("f0_data_addr_ok", data_addr_ok, 0);
    cyc();
    m_data_ok = 1;
    #1;
    chk("f1_m_req", m_req, 0);
    chk("f1_data_addr_ok", data_addr_ok, 0);
    chk("f1_data_data_ok", data_data_ok, 1);
    cyc();
    #1;
    chk("f2_m_req", m_req, 1);
    chk("f2_data_addr_ok", data_addr_ok, 1);
    chk("f2_inst_data_ok", inst_data_ok, 1);
    cyc();
    m_data_ok = 0; data_addr = 32'h0000_0600;
    #1 chk("f3_data_addr_ok", data_addr_ok, 1);
    cyc();
    data_addr = 32'h0000_0700;
    #1;
    chk("f4_m_req", m_req, 0);
    chk("f4_data_addr_ok", data_addr_ok, 0);
    cyc();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1 chk("f5_data_data_ok", data_data_ok, 1);
    cyc();
    #1 chk("f6_data_data_ok", data_data_ok, 1);

    // unexpected response with nothing outstanding
    cyc();
    #1;
    chk("ux_data_data_ok", data_data_ok, 0);
    chk("ux_inst_data_ok", inst_data_ok, 0);
    chk("ux_err_before", err_unexp, 0);
    cyc();
    m_data_ok = 0;
    #1 chk("ux_err_set", err_unexp, 1);
    cyc();
    #1 chk("ux_err_sticky", err_unexp, 1);

    // reset with two outstanding
    cyc();
    data_req = 1; data_addr = 32'h0000_0800; m_addr_ok = 1;
    #1 chk("r0_data_addr_ok", data_addr_ok, 1);
    cyc();
    #1 chk("r1_data_addr_ok", data_addr_ok, 1);
    cyc();
    #1 chk("r2_full_m_req", m_req, 0);
    resetn = 0; data_req = 0; m_addr_ok = 0;
    cyc();
    resetn = 1;
    #1;
    chk("r3_err_cleared", err_unexp, 0);
    m_data_ok = 1;
    #1;
    chk("r3_data_data_ok", data_data_ok, 0);
    chk("r3_inst_data_ok", inst_data_ok, 0);
    cyc();
    m_data_ok = 0;
    #1 chk("r4_err_set", err_unexp, 1);

    // starvation: D,D,D,D,I repeating
    for (int k = 0; k < 10; k++) begin
      cyc();
      inst_req = 1; inst_addr = 32'h0000_1000;
      data_req = 1; data_addr = 32'h0000_2000;
      m_addr_ok = 1; m_data_ok = (k > 0);
      #1;
      chk($sformatf("stv%0d_data_addr_ok", k), data_addr_ok, (k % 5 != 4));
      chk($sformatf("stv%0d_inst_addr_ok", k), inst_addr_ok, (k % 5 == 4));
    end

    cyc();
    inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
